// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IFU) and load/store
//   (MAU). The MAU has fixed priority. A starvation guard forces the IFU to
//   win once the MAU has been granted STARVE_LIMIT times in a row while the
//   IFU was waiting. Only one bus transaction is outstanding at a time.
//
// Parameters
//   ADDR_W, DATA_W        address / data width (byte enables are DATA_W/8)
//   STARVE_LIMIT          MAU grants against a waiting IFU before the IFU wins
//   TIMEOUT_CYCLES        BUSY cycles without ack before abort
//                         (only with MEM_TIMEOUT_EN)
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   ifu_req/ifu_addr      fetch request (level, held until ifu_done)
//   ifu_rdata/ifu_done    fetched word, one-cycle completion pulse
//   mau_req/we/be/addr/wdata  load/store request (level, held until mau_done)
//   mau_rdata/mau_done    load data, one-cycle completion pulse
//   mem_req/we/be/addr/wdata  registered bus command
//   mem_rdata/mem_ack     bus read data, one-cycle completion
//   mau_data_conflict     combinational: IFU is blocked by the MAU
//   mem_timeout           one-cycle abort pulse (only with MEM_TIMEOUT_EN)
//
// Build option
//   `define MEM_TIMEOUT_EN adds the BUSY watchdog and the mem_timeout port.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_done,
  input  logic                mau_req,
  input  logic                mau_we,
  input  logic [DATA_W/8-1:0] mau_be,
  input  logic [ADDR_W-1:0]   mau_addr,
  input  logic [DATA_W-1:0]   mau_wdata,
  output logic [DATA_W-1:0]   mau_rdata,
  output logic                mau_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                mau_data_conflict
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                mem_timeout
`endif
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IFU_BUSY, MAU_BUSY} state_t;

  state_t            state, state_d;
  logic [SC_W-1:0]   starve_cnt, starve_d;

  logic              mem_req_d, mem_we_d;
  logic [BE_W-1:0]   mem_be_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              ifu_done_d, mau_done_d;
  logic [DATA_W-1:0] ifu_rdata_d, mau_rdata_d;

  logic              ifu_elig, mau_elig, mau_wins, ifu_wins;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0]   busy_cnt, busy_cnt_d;
  logic              mem_timeout_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ifu_done   <= 1'b0;
      mau_done   <= 1'b0;
      ifu_rdata  <= '0;
      mau_rdata  <= '0;
`ifdef MEM_TIMEOUT_EN
      busy_cnt    <= '0;
      mem_timeout <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      starve_cnt <= starve_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_be     <= mem_be_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      ifu_done   <= ifu_done_d;
      mau_done   <= mau_done_d;
      ifu_rdata  <= ifu_rdata_d;
      mau_rdata  <= mau_rdata_d;
`ifdef MEM_TIMEOUT_EN
      busy_cnt    <= busy_cnt_d;
      mem_timeout <= mem_timeout_d;
`endif
    end
  end

  always_comb begin
    // A requester in its done cycle is not eligible, so a held req is
    // never re-sampled as a second request in that cycle.
    ifu_elig = ifu_req & ~ifu_done;
    mau_elig = mau_req & ~mau_done;
    mau_wins = (state == IDLE) & mau_elig & ~(ifu_elig & (starve_cnt == SC_MAX));
    ifu_wins = (state == IDLE) & ifu_elig & ~mau_wins;

    mau_data_conflict = ifu_req & ~ifu_done & ((state == MAU_BUSY) | mau_wins);

    state_d     = state;
    starve_d    = starve_cnt;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_be_d    = mem_be;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    ifu_done_d  = 1'b0;
    mau_done_d  = 1'b0;
    ifu_rdata_d = ifu_rdata;
    mau_rdata_d = mau_rdata;
`ifdef MEM_TIMEOUT_EN
    busy_cnt_d    = busy_cnt;
    mem_timeout_d = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (mau_wins) begin
          state_d     = MAU_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = mau_we;
          mem_be_d    = mau_be;
          mem_addr_d  = mau_addr;
          mem_wdata_d = mau_wdata;
          if (ifu_elig && starve_cnt != SC_MAX) begin
            starve_d = starve_cnt + SC_W'(1);
          end
`ifdef MEM_TIMEOUT_EN
          busy_cnt_d = '0;
`endif
        end else if (ifu_wins) begin
          state_d     = IFU_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = ifu_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
`ifdef MEM_TIMEOUT_EN
          busy_cnt_d = '0;
`endif
        end
      end
      IFU_BUSY, MAU_BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state == IFU_BUSY) begin
            ifu_done_d  = 1'b1;
            ifu_rdata_d = mem_rdata;
          end else begin
            mau_done_d  = 1'b1;
            mau_rdata_d = mem_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        // An ack on the limit cycle wins (handled above); otherwise abort.
        else if (busy_cnt == TO_LAST) begin
          state_d       = IDLE;
          mem_req_d     = 1'b0;
          mem_timeout_d = 1'b1;
          if (state == IFU_BUSY) begin
            ifu_done_d  = 1'b1;
            ifu_rdata_d = '0;
          end else begin
            mau_done_d  = 1'b1;
            mau_rdata_d = '0;
          end
        end else begin
          busy_cnt_d = busy_cnt + TO_W'(1);
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// request/ack traffic, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int          LIMIT  = 4;
  localparam int          TO_CYC = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              ifu_req;
  logic [ADDR_W-1:0] ifu_addr;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_done;
  logic              mau_req, mau_we;
  logic [BE_W-1:0]   mau_be;
  logic [ADDR_W-1:0] mau_addr;
  logic [DATA_W-1:0] mau_wdata, mau_rdata;
  logic              mau_done;
  logic              mem_req, mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ack;
  logic              mau_data_conflict;
`ifdef MEM_TIMEOUT_EN
  logic              mem_timeout;
`endif

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata), .ifu_done(ifu_done),
    .mau_req(mau_req), .mau_we(mau_we), .mau_be(mau_be), .mau_addr(mau_addr),
    .mau_wdata(mau_wdata), .mau_rdata(mau_rdata), .mau_done(mau_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mau_data_conflict(mau_data_conflict)
`ifdef MEM_TIMEOUT_EN
    , .mem_timeout(mem_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus (-1 none, 0 IFU, 1 MAU), the command
  // it must present, and the done/rdata the DUT must show this cycle.
  int                owner, streak, ack_wait, ack_delay, busy_cycles;
  bit                spur_ack, fixed_rd_en;
  logic [DATA_W-1:0] fixed_rd;
  logic [ADDR_W-1:0] x_addr;
  logic              x_we;
  logic [BE_W-1:0]   x_be;
  logic [DATA_W-1:0] x_wdata, x_ifu_rdata, x_mau_rdata;
  logic              x_ifu_done, x_mau_done, x_timeout;
  logic              prev_mem_req;
  int                grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic ir, input logic im, input logic idn,
                              input logic mdn, input int stk);
    logic ie, me;
    ie = ir && !idn;
    me = im && !mdn;
    if (me && !(ie && stk >= LIMIT)) return 1;
    if (ie) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; streak = 0; ack_wait = 0; busy_cycles = 0;
    x_addr = '0; x_we = 1'b0; x_be = '0; x_wdata = '0;
    x_ifu_rdata = '0; x_mau_rdata = '0;
    x_ifu_done = 1'b0; x_mau_done = 1'b0; x_timeout = 1'b0;
    prev_mem_req = 1'b0;
  endtask

  // One clock: check the combinational conflict, cross the edge, advance
  // the model, check registered outputs, then drive the bus response.
  task automatic cycle();
    int w;
    logic nd_i, nd_m, nt;
    #1;
    w = (owner < 0) ? pick(ifu_req, mau_req, x_ifu_done, x_mau_done, streak) : -1;
    chk("conflict", 64'(mau_data_conflict),
        64'(ifu_req && !x_ifu_done && (owner == 1 || w == 1)));
    @(posedge clk);
    nd_i = 1'b0; nd_m = 1'b0; nt = 1'b0;
    if (owner >= 0) begin
      if (mem_ack) begin
        if (owner == 0) begin nd_i = 1'b1; x_ifu_rdata = mem_rdata; end
        else begin nd_m = 1'b1; x_mau_rdata = mem_rdata; end
        owner = -1;
      end
`ifdef MEM_TIMEOUT_EN
      else if (busy_cycles == TO_CYC - 1) begin
        if (owner == 0) begin nd_i = 1'b1; x_ifu_rdata = '0; end
        else begin nd_m = 1'b1; x_mau_rdata = '0; end
        nt = 1'b1;
        owner = -1;
      end
`endif
      else busy_cycles++;
    end else if (w == 1) begin
      if (ifu_req && !x_ifu_done && streak < LIMIT) streak++;
      owner = 1;
      x_addr = mau_addr; x_we = mau_we; x_be = mau_be; x_wdata = mau_wdata;
    end else if (w == 0) begin
      streak = 0;
      owner = 0;
      x_addr = ifu_addr; x_we = 1'b0; x_be = '1; x_wdata = '0;
    end
    if (w >= 0) begin
      busy_cycles = 0;
      ack_wait = (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
    end
    x_ifu_done = nd_i; x_mau_done = nd_m; x_timeout = nt;
    #1;
    chk("mem_req", 64'(mem_req), 64'(owner >= 0));
    if (owner >= 0) begin
      chk("mem_addr", 64'(mem_addr), 64'(x_addr));
      chk("mem_we", 64'(mem_we), 64'(x_we));
      chk("mem_be", 64'(mem_be), 64'(x_be));
      chk("mem_wdata", 64'(mem_wdata), 64'(x_wdata));
    end
    chk("ifu_done", 64'(ifu_done), 64'(x_ifu_done));
    chk("mau_done", 64'(mau_done), 64'(x_mau_done));
    chk("done_overlap", 64'(ifu_done && mau_done), 64'(0));
    if (x_ifu_done) chk("ifu_rdata", 64'(ifu_rdata), 64'(x_ifu_rdata));
    if (x_mau_done) chk("mau_rdata", 64'(mau_rdata), 64'(x_mau_rdata));
`ifdef MEM_TIMEOUT_EN
    chk("mem_timeout", 64'(mem_timeout), 64'(x_timeout));
`endif
    if (mem_req && !prev_mem_req)
      grant_log.push_back((mem_addr == ifu_addr && !mem_we && mem_be == 4'hF) ? 0 : 1);
    prev_mem_req = mem_req;
    if (owner >= 0) begin
      if (ack_wait == 0) begin
        mem_ack = 1'b1;
        mem_rdata = fixed_rd_en ? fixed_rd : DATA_W'($urandom);
      end else begin
        mem_ack = 1'b0;
        ack_wait--;
      end
    end else begin
      mem_ack = spur_ack && ($urandom_range(0, 2) == 0);
      mem_rdata = DATA_W'($urandom);
    end
  endtask

  // Run until the given requester (0 IFU, 1 MAU) completes; it drops its
  // request in the done cycle. n is the cycle index of the done pulse.
  task automatic wait_done(input int who, input int maxc, output int n);
    n = -1;
    for (int i = 0; i < maxc; i++) begin
      cycle();
      if (who == 0 && ifu_done === 1'b1) begin ifu_req = 1'b0; n = i; break; end
      if (who == 1 && mau_done === 1'b1) begin mau_req = 1'b0; n = i; break; end
    end
    chk("done_within_bound", 64'(n >= 0), 64'(1));
  endtask

  initial begin
    int n;
    reset = 1'b0;
    ifu_req = 1'b0; ifu_addr = '0;
    mau_req = 1'b0; mau_we = 1'b0; mau_be = '0; mau_addr = '0; mau_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    ack_delay = -1; spur_ack = 1'b0; fixed_rd_en = 1'b0; fixed_rd = '0;
    model_reset();
    #12;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_be", 64'(mem_be), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_ifu_done", 64'(ifu_done), 64'(0));
    chk("rst_mau_done", 64'(mau_done), 64'(0));
    chk("rst_ifu_rdata", 64'(ifu_rdata), 64'(0));
    chk("rst_mau_rdata", 64'(mau_rdata), 64'(0));
    reset = 1'b1;
    cycle();

    // IFU alone, ack two cycles after mem_req.
    ack_delay = 2; fixed_rd_en = 1'b1; fixed_rd = 32'h0000_0013;
    ifu_req = 1'b1; ifu_addr = 32'h100;
    wait_done(0, 12, n);
    chk("ifu_only_latency", 64'(n), 64'(3));
    chk("ifu_only_rdata", 64'(ifu_rdata), 64'(32'h13));
    fixed_rd_en = 1'b0;
    cycle();

    // Simultaneous requests: MAU first, then IFU.
    grant_log.delete();
    ack_delay = 1;
    ifu_req = 1'b1; ifu_addr = 32'h104;
    mau_req = 1'b1; mau_we = 1'b0; mau_be = 4'hF; mau_addr = 32'h2004; mau_wdata = '0;
    wait_done(1, 12, n);
    wait_done(0, 12, n);
    chk("both_grants", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() == 2) begin
      chk("both_first_mau", 64'(grant_log[0]), 64'(1));
      chk("both_then_ifu", 64'(grant_log[1]), 64'(0));
    end
    cycle();

    // MAU store held through a 5-cycle ack wait.
    ack_delay = 5;
    mau_req = 1'b1; mau_we = 1'b1; mau_be = 4'b0011; mau_addr = 32'h2000; mau_wdata = 32'hA5A5_A5A5;
    wait_done(1, 20, n);
    chk("store_latency", 64'(n), 64'(6));
    cycle();

    // Starvation guard: IFU eligible at every arbitration where the MAU is.
    grant_log.delete();
    ack_delay = 0;
    ifu_req = 1'b1; ifu_addr = 32'h1000_0040;
    mau_req = 1'b1; mau_we = 1'b0; mau_be = 4'hF; mau_addr = 32'h2000_0100;
    n = -1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (ifu_done === 1'b1) begin n = i; break; end
      if (mau_done === 1'b1) begin mau_addr = mau_addr + 32'd4; ifu_req = 1'b0; end
      else ifu_req = 1'b1;
    end
    ifu_req = 1'b0; mau_req = 1'b0;
    chk("starve_ifu_served", 64'(n >= 0), 64'(1));
    chk("starve_grants", 64'(grant_log.size()), 64'(LIMIT + 1));
    for (int i = 0; i < grant_log.size(); i++)
      chk("starve_order", 64'(grant_log[i]), 64'((i == LIMIT) ? 0 : 1));
    cycle();

    // Reset while the MAU owns the bus.
    ack_delay = 100;
    mau_req = 1'b1; mau_we = 1'b0; mau_be = 4'hF; mau_addr = 32'h3000;
    cycle();
    cycle();
    chk("pre_reset_busy", 64'(mem_req), 64'(1));
    reset = 1'b0;
    #1;
    chk("reset_drops_req", 64'(mem_req), 64'(0));
    chk("reset_mem_addr", 64'(mem_addr), 64'(0));
    chk("reset_mau_done", 64'(mau_done), 64'(0));
    model_reset();
    mau_req = 1'b0;
    #1;
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    cycle();
    cycle();
    ack_delay = 1;
    ifu_req = 1'b1; ifu_addr = 32'h200;
    wait_done(0, 12, n);
    cycle();

    // Random traffic.
    ack_delay = -1; spur_ack = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (ifu_req ? (ifu_done === 1'b1) : ($urandom_range(0, 2) == 0)) begin
        ifu_req = (!ifu_req) || ($urandom_range(0, 1) == 1);
        ifu_addr = ADDR_W'($urandom) & ~ADDR_W'(3);
      end
      if (mau_req ? (mau_done === 1'b1) : ($urandom_range(0, 2) == 0)) begin
        mau_req = (!mau_req) || ($urandom_range(0, 1) == 1);
        mau_we = 1'($urandom_range(0, 1));
        mau_be = BE_W'($urandom_range(1, 15));
        mau_addr = ADDR_W'($urandom);
        mau_wdata = DATA_W'($urandom);
      end
    end
    spur_ack = 1'b0;
    for (int i = 0; i < 100 && (ifu_req || mau_req || owner >= 0); i++) begin
      cycle();
      if (ifu_done === 1'b1) ifu_req = 1'b0;
      if (mau_done === 1'b1) mau_req = 1'b0;
    end
    chk("drain", 64'(ifu_req || mau_req || mem_req), 64'(0));

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after TIMEOUT_CYCLES BUSY cycles.
    ack_delay = 1000;
    ifu_req = 1'b1; ifu_addr = 32'h400;
    wait_done(0, 40, n);
    chk("timeout_latency", 64'(n), 64'(TO_CYC));
    chk("timeout_pulse", 64'(mem_timeout), 64'(1));
    chk("timeout_rdata", 64'(ifu_rdata), 64'(0));
    cycle();
    chk("timeout_idle", 64'(mem_req), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the IFU (instruction fetch) and the MAU (load/store).
- Fixed priority to the MAU, plus an IFU starvation guard.
- Produces mau_data_conflict, which feeds the run control unit to stall IFU/DECODE/REGFILE.
- Sits between the IFU/MAU and the memory bus. One transaction is outstanding at a time.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8 bits
STARVE_LIMIT, 4, number of consecutive MAU grants against a waiting IFU before the IFU is forced to win
TIMEOUT_CYCLES, 16, BUSY-state cycles without ack before abort (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ifu_req  in  1  IFU read request, level; held with ifu_addr until ifu_done
ifu_addr  in  ADDR_W  fetch address
ifu_rdata  out  DATA_W  fetched word; valid while ifu_done=1
ifu_done  out  1  one-cycle completion pulse
mau_req  in  1  MAU request, level; held with operands until mau_done
mau_we  in  1  1=store, 0=load
mau_be  in  DATA_W/8  byte enables
mau_addr  in  ADDR_W  data address
mau_wdata  in  DATA_W  store data
mau_rdata  out  DATA_W  load data; valid while mau_done=1
mau_done  out  1  one-cycle completion pulse
mem_req  out  1  bus request, registered
mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered bus command
mem_rdata  in  DATA_W  bus read data, valid with mem_ack
mem_ack  in  1  one-cycle bus completion
mau_data_conflict  out  1  IFU blocked by MAU; combinational

Behaviour:
- FSM states: IDLE, IFU_BUSY, MAU_BUSY.
- Reset (asynchronous, active-low) forces:
  - state = IDLE, starve_cnt = 0
  - all mem_* = 0, both done = 0, both rdata = 0
- Reset mid-transaction: mem_req drops immediately; a later mem_ack is ignored.
- Eligibility in IDLE: a requester is eligible if its req=1 and its done=0 that cycle. The requester may drop req in its done cycle; its req is not re-sampled in the done cycle.
- Arbitration in IDLE, MAU wins if eligible, unless the IFU is also eligible and starve_cnt == STARVE_LIMIT; otherwise an eligible IFU wins.
- On grant (edge N):
  - Latch the winner's addr/we/be/wdata into mem_*. For IFU: we=0, be=all ones, wdata=0.
  - mem_req=1 from cycle N+1; go to the owner's BUSY state.
- In BUSY: mem_* held stable until mem_ack=1.
- On the ack edge:
  - Capture mem_rdata into the owner's rdata.
  - Owner's done=1 for exactly one cycle.
  - mem_req=0; state returns to IDLE.
- Latency: request to done = ack latency + 1 cycle. Minimum 2 cycles between grants to the same requester.
- mem_ack while IDLE is ignored.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - +1 on each MAU grant made while the IFU is eligible; saturates at STARVE_LIMIT.
  - Cleared on every IFU grant.
- mau_data_conflict = ifu_req & ~ifu_done & (state==MAU_BUSY | (state==IDLE & MAU wins this cycle)).
- ifu_done and mau_done are never high in the same cycle.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - Adds port mem_timeout (out, 1) and a BUSY cycle counter, cleared on entering BUSY.
  - If the counter reaches TIMEOUT_CYCLES with no ack: mem_req=0, owner's done pulses with rdata=0, mem_timeout pulses for the same one cycle, state returns to IDLE.
  - An ack in the same cycle as the limit takes priority: normal completion, no timeout.
- When undefined: no port, no counter; BUSY waits indefinitely for mem_ack.

Test Plan:
- IFU only, ifu_addr=0x100, ack 2 cycles after mem_req, mem_rdata=0x00000013 -> mem_addr=0x100, mem_we=0; ifu_done one cycle with ifu_rdata=0x13; mau_data_conflict stays 0.
- Both request in the same cycle, starve_cnt=0 -> MAU granted first; mau_data_conflict=1 until mau_done; IFU granted next; starve_cnt back to 0.
- MAU store: be=4'b0011, wdata=0xA5A5A5A5, addr=0x2000 -> mem_we=1, mem_be=0011, values stable through a 5-cycle ack wait; mau_done one cycle.
- IFU held requesting, MAU issuing back-to-back -> after 4 MAU grants the IFU wins the 5th arbitration; no done overlap.
- reset low while MAU_BUSY -> mem_req=0 immediately; later mem_ack gives no done; fresh ifu_req served normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> after 16 BUSY cycles mem_timeout and ifu_done pulse together, ifu_rdata=0, FSM returns to IDLE.
